ymc_sequencer: RTL

//   Multi-cycle control sequencer for the yChip datapath. Steps each RV32I

---
 rtl/ymc_sequencer.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/ymc_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the yChip RV32I datapath.
// A single memory port is shared between instruction fetch and data accesses, gated by mem_ready.
module ymc_sequencer #(
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             INT,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             addr_sel,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             reg_write,
    output logic             alu_src,
    output logic [1:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] ins_count,
    output logic             error
);

    localparam int WAIT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        C_R    = 3'd0,
        C_I    = 3'd1,
        C_LD   = 3'd2,
        C_ST   = 3'd3,
        C_BR   = 3'd4,
        C_JAL  = 3'd5,
        C_HALT = 3'd6,
        C_ILL  = 3'd7
    } cls_t;

    function automatic cls_t op_class(input logic [6:0] op);
        case (op)
            7'b0110011: op_class = C_R;
            7'b0010011: op_class = C_I;
            7'b0000011: op_class = C_LD;
            7'b0100011: op_class = C_ST;
            7'b1100011: op_class = C_BR;
            7'b1101111: op_class = C_JAL;
            7'b0000000: op_class = C_HALT;
            default:    op_class = C_ILL;
        endcase
    endfunction

    state_t            cur, nxt;
    cls_t              cls, dec_cls;
    logic [WAIT_W-1:0] wait_cnt;
    logic              stalled, timeout, retire;

    assign dec_cls = op_class(opcode);
    assign stalled = ((cur == S_FETCH) || (cur == S_MEM)) && !mem_ready;
    // The WAIT_MAX-th consecutive not-ready cycle is the one that finds the count at WAIT_MAX-1.
    assign timeout = stalled && (wait_cnt == WAIT_W'(WAIT_MAX - 1));

    always_ff @(posedge clk) begin
        if (INT) begin
            cur       <= S_FETCH;
            cls       <= C_R;
            wait_cnt  <= '0;
            ins_count <= '0;
        end else begin
            cur <= nxt;
            if (cur == S_DECODE)
                cls <= dec_cls;
            if (nxt != cur)
                wait_cnt <= '0;
            else if (stalled)
                wait_cnt <= wait_cnt + 1'b1;
            if (retire)
                ins_count <= ins_count + 1'b1;
        end
    end

    always_comb begin
        nxt    = cur;
        retire = 1'b0;
        case (cur)
            S_FETCH: begin
                if (mem_ready)
                    nxt = S_DECODE;
                else if (timeout)
                    nxt = S_ERROR;
            end
            S_DECODE: begin
                case (dec_cls)
                    C_HALT:  nxt = S_HALT;
                    C_ILL:   nxt = S_ERROR;
                    default: nxt = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (cls)
                    C_R, C_I:    nxt = S_WB;
                    C_LD, C_ST:  nxt = S_MEM;
                    C_BR, C_JAL: begin
                        nxt    = S_FETCH;
                        retire = 1'b1;
                    end
                    default:     nxt = S_ERROR;
                endcase
            end
            S_MEM: begin
                if (mem_ready) begin
                    if (cls == C_ST) begin
                        nxt    = S_FETCH;
                        retire = 1'b1;
                    end else begin
                        nxt = S_WB;
                    end
                end else if (timeout) begin
                    nxt = S_ERROR;
                end
            end
            S_WB: begin
                nxt    = S_FETCH;
                retire = 1'b1;
            end
            default: nxt = cur;
        endcase
    end

    always_comb begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
        addr_sel  = 1'b0;
        ir_write  = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 2'd0;
        reg_write = 1'b0;
        alu_src   = 1'b0;
        alu_op    = 2'd0;
        wb_sel    = 2'd0;
        if (!INT) begin
            case (cur)
                S_FETCH: begin
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                S_EXEC: begin
                    case (cls)
                        C_R: alu_op = 2'd2;
                        C_I: begin
                            alu_op  = 2'd2;
                            alu_src = 1'b1;
                        end
                        C_LD, C_ST: alu_src = 1'b1;
                        C_BR: begin
                            alu_op   = 2'd1;
                            pc_write = zero;
                            pc_src   = 2'd1;
                        end
                        C_JAL: begin
                            pc_write  = 1'b1;
                            pc_src    = 2'd2;
                            reg_write = 1'b1;
                            wb_sel    = 2'd2;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    addr_sel  = 1'b1;
                    alu_src   = 1'b1;
                    mem_read  = (cls == C_LD);
                    mem_write = (cls == C_ST);
                end
                S_WB: begin
                    reg_write = 1'b1;
                    case (cls)
                        C_R: alu_op = 2'd2;
                        C_I: begin
                            alu_op  = 2'd2;
                            alu_src = 1'b1;
                        end
                        C_LD: begin
                            alu_src = 1'b1;
                            wb_sel  = 2'd1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign state = cur;
    assign error = (cur == S_ERROR);

endmodule
